plain_broadcast_packer: RTL and testbench

PLAIN_BROADCAST_PACKER -- requirements
Module: plain_broadcast_packer

---
 rtl/plain_broadcast_packer.sv | 136 +++++++++++++
 tb/tb_plain_broadcast_packer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plain_broadcast_packer.sv
// Packs each captured alpha/beta broadcast into consecutive 32-bit hash-input RAM writes.
// Optional macro BROADCAST_OVF_DETECT_EN adds a sticky o_ovf flag for i_valid pulses that are dropped.
module plain_broadcast_packer #(
    parameter string PARAMETER_SET = "L5",
    parameter int    T             = (PARAMETER_SET == "L5") ? 4 : 3,
    parameter int    TAU           = 17,
    parameter int    N_WORDS       = 2 * T * TAU
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic                                       i_start,
    input  logic                                       i_valid,
    input  logic [32*T-1:0]                            i_alpha,
    input  logic [32*T-1:0]                            i_beta,
    output logic                                       o_wr_en,
    output logic [((N_WORDS > 1) ? $clog2(N_WORDS) : 1)-1:0] o_wr_addr,
    output logic [31:0]                                o_wr_data,
    output logic                                       o_busy,
    output logic                                       o_done
`ifdef BROADCAST_OVF_DETECT_EN
    ,
    output logic                                       o_ovf
`endif
);

    localparam int AW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int IW = (TAU > 1) ? $clog2(TAU) : 1;
    localparam int W  = 2 * T;
    localparam int JW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_WAIT_START,
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state;
    logic [IW-1:0]      iter;
    logic [JW-1:0]      j;
    logic [W-1:0][31:0] cap_q;
    logic [31:0]        cur_word;
    logic [AW-1:0]      cur_addr;

    // Word 0 goes out on the capture edge itself, so j here always points at words 1..2T-1.
    always_comb begin
        cur_word = '0;
        for (int unsigned k = 0; k < W; k++) begin
            if (j == JW'(k)) cur_word = cap_q[k];
        end
    end

    assign cur_addr = AW'(iter) * AW'(W) + AW'(j);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_WAIT_START;
            iter      <= '0;
            j         <= '0;
            cap_q     <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
`ifdef BROADCAST_OVF_DETECT_EN
            o_ovf     <= 1'b0;
`endif
        end else if (i_start) begin
            state     <= S_IDLE;
            iter      <= '0;
            j         <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
`ifdef BROADCAST_OVF_DETECT_EN
            o_ovf     <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                S_WAIT_START: begin
`ifdef BROADCAST_OVF_DETECT_EN
                    if (i_valid) o_ovf <= 1'b1;
`endif
                end
                S_IDLE: begin
                    if (i_valid) begin
                        // Packed layout puts alpha lane k at word k and beta lane k at word T+k.
                        cap_q     <= {i_beta, i_alpha};
                        o_wr_en   <= 1'b1;
                        o_busy    <= 1'b1;
                        o_wr_addr <= AW'(iter) * AW'(W);
                        o_wr_data <= i_alpha[31:0];
                        j         <= JW'(1);
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
`ifdef BROADCAST_OVF_DETECT_EN
                    if (i_valid) o_ovf <= 1'b1;
`endif
                    if (j == JW'(W)) begin
                        o_wr_en   <= 1'b0;
                        o_busy    <= 1'b0;
                        o_wr_addr <= '0;
                        o_wr_data <= '0;
                        j         <= '0;
                        if (iter == IW'(TAU - 1)) begin
                            iter   <= '0;
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            iter  <= iter + 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        o_wr_addr <= cur_addr;
                        o_wr_data <= cur_word;
                        j         <= j + 1'b1;
                    end
                end
                S_DONE: begin
`ifdef BROADCAST_OVF_DETECT_EN
                    if (i_valid) o_ovf <= 1'b1;
`endif
                    state <= S_WAIT_START;
                end
                default: state <= S_WAIT_START;
            endcase
        end
    end

endmodule

// File: tb/tb_plain_broadcast_packer.sv
// Directed bench for plain_broadcast_packer: L5 and L1 instances share stimulus, outputs selected by use_l1.
module tb_plain_broadcast_packer;

    logic         clk;
    logic         rst;
    logic         start;
    logic         valid;
    logic [127:0] alpha;
    logic [127:0] beta;

    logic        wr_en5, busy5, done5;
    logic [7:0]  addr5;
    logic [31:0] data5;
    logic        wr_en1, busy1, done1;
    logic [6:0]  addr1;
    logic [31:0] data1;
`ifdef BROADCAST_OVF_DETECT_EN
    logic        ovf5, ovf1;
`endif

    bit          use_l1;
    logic        c_en, c_busy, c_done;
    logic [31:0] c_addr, c_data;

    int n_checks = 0;
    int n_fail   = 0;

    plain_broadcast_packer #(.PARAMETER_SET("L5")) dut5 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
        .i_alpha(alpha), .i_beta(beta),
        .o_wr_en(wr_en5), .o_wr_addr(addr5), .o_wr_data(data5),
        .o_busy(busy5), .o_done(done5)
`ifdef BROADCAST_OVF_DETECT_EN
        , .o_ovf(ovf5)
`endif
    );

    plain_broadcast_packer #(.PARAMETER_SET("L1")) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
        .i_alpha(alpha[95:0]), .i_beta(beta[95:0]),
        .o_wr_en(wr_en1), .o_wr_addr(addr1), .o_wr_data(data1),
        .o_busy(busy1), .o_done(done1)
`ifdef BROADCAST_OVF_DETECT_EN
        , .o_ovf(ovf1)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        if (use_l1) begin
            c_en = wr_en1; c_busy = busy1; c_done = done1;
            c_addr = {25'd0, addr1}; c_data = data1;
        end else begin
            c_en = wr_en5; c_busy = busy5; c_done = done5;
            c_addr = {24'd0, addr5}; c_data = data5;
        end
    end

    typedef struct {
        logic [127:0]      alpha;
        logic [127:0]      beta;
        logic [0:7][31:0]  exp;
        int                glitch;
    } vec_t;

    vec_t tbl [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_wr_en"}, {31'd0, c_en}, 32'd0);
        chk({tag, "_busy"},  {31'd0, c_busy}, 32'd0);
        chk({tag, "_addr"},  c_addr, 32'd0);
        chk({tag, "_data"},  c_data, 32'd0);
    endtask

    function automatic logic [127:0] gen_lanes(input logic [7:0] tag, input int c);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = {tag, 8'(c), 8'h00, 8'(k)};
        return r;
    endfunction

    function automatic logic [0:7][31:0] gen_exp(input int c, input int t);
        logic [0:7][31:0] w;
        w = '0;
        for (int j = 0; j < 2*t; j++) begin
            if (j < t) w[j] = {8'hC0, 8'(c), 8'h00, 8'(j)};
            else       w[j] = {8'hB0, 8'(c), 8'h00, 8'(j - t)};
        end
        return w;
    endfunction

    // Pulses i_valid, checks every write word, then the cycle after the last write.
    task automatic capture(input logic [127:0] a, input logic [127:0] b,
                           input logic [0:7][31:0] exp, input int base, input int nw,
                           input bit exp_done, input int glitch, input int abort,
                           input string tag);
        alpha = a; beta = b; valid = 1'b1;
        step();
        valid = 1'b0;
        for (int j = 0; j < nw; j++) begin
            chk($sformatf("%s_w%0d_en", tag, j),   {31'd0, c_en}, 32'd1);
            chk($sformatf("%s_w%0d_busy", tag, j), {31'd0, c_busy}, 32'd1);
            chk($sformatf("%s_w%0d_addr", tag, j), c_addr, 32'(base + j));
            chk($sformatf("%s_w%0d_data", tag, j), c_data, exp[j]);
            chk($sformatf("%s_w%0d_done", tag, j), {31'd0, c_done}, 32'd0);
            if (j == glitch) valid = 1'b1;
            if (j == abort)  start = 1'b1;
            step();
            valid = 1'b0;
            start = 1'b0;
            if (j == abort) begin
                chk_idle({tag, "_abort"});
                return;
            end
        end
        chk_idle({tag, "_end"});
        chk({tag, "_done"}, {31'd0, c_done}, {31'd0, exp_done});
        step();
        chk({tag, "_done_after"}, {31'd0, c_done}, 32'd0);
        chk_idle({tag, "_after"});
    endtask

    task automatic count_quiet(input string tag, input int cycles);
        int en_cnt;
        int dn_cnt;
        en_cnt = 0;
        dn_cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (c_en)   en_cnt++;
            if (c_done) dn_cnt++;
            step();
        end
        chk({tag, "_writes"}, 32'(en_cnt), 32'd0);
        chk({tag, "_dones"},  32'(dn_cnt), 32'd0);
    endtask

    initial begin
        tbl[0].alpha  = {32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        tbl[0].beta   = {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0};
        tbl[0].exp    = {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201,
                         32'h000000A0, 32'h000000A1, 32'h000000A2, 32'h000000A3};
        tbl[0].glitch = 2;
        tbl[1].alpha  = {32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 32'h12345678};
        tbl[1].beta   = {32'h80000001, 32'h7FFFFFFE, 32'h55555555, 32'hAAAAAAAA};
        tbl[1].exp    = {32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'hDEADBEEF,
                         32'hAAAAAAAA, 32'h55555555, 32'h7FFFFFFE, 32'h80000001};
        tbl[1].glitch = -1;
        tbl[2].alpha  = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        tbl[2].beta   = {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        tbl[2].exp    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111,
                         32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
        tbl[2].glitch = -1;

        clk = 1'b0; rst = 1'b1; start = 1'b0; valid = 1'b0;
        alpha = '0; beta = '0; use_l1 = 1'b0;

        @(negedge clk);
        step();
        chk_idle("rst5");
        chk("rst5_done", {31'd0, c_done}, 32'd0);
        use_l1 = 1'b1;
        #1;
        chk_idle("rst1");
        use_l1 = 1'b0;
        #1;
        rst = 1'b0;
        step();

        // i_valid before any i_start is dropped
        valid = 1'b1;
        step();
        valid = 1'b0;
        count_quiet("pre_start", 10);
`ifdef BROADCAST_OVF_DETECT_EN
        chk("pre_start_ovf", {31'd0, ovf5}, 32'd1);
`endif

        start = 1'b1;
        step();
        start = 1'b0;
`ifdef BROADCAST_OVF_DETECT_EN
        chk("start_clears_ovf", {31'd0, ovf5}, 32'd0);
`endif

        for (int i = 0; i < 3; i++)
            capture(tbl[i].alpha, tbl[i].beta, tbl[i].exp, i*8, 8, 1'b0,
                    tbl[i].glitch, -1, $sformatf("tbl%0d", i));
`ifdef BROADCAST_OVF_DETECT_EN
        chk("glitch_ovf", {31'd0, ovf5}, 32'd1);
`endif

        for (int c = 3; c < 17; c++)
            capture(gen_lanes(8'hC0, c), gen_lanes(8'hB0, c), gen_exp(c, 4), c*8, 8,
                    (c == 16), -1, -1, $sformatf("cap%0d", c));

        // Back in S_WAIT_START: a further i_valid must not write
        valid = 1'b1;
        step();
        valid = 1'b0;
        count_quiet("post_done", 10);

        // Simultaneous i_start and i_valid: start wins, nothing captured
        start = 1'b1;
        valid = 1'b1;
        step();
        start = 1'b0;
        valid = 1'b0;
        count_quiet("start_valid", 8);

        for (int c = 0; c < 5; c++)
            capture(gen_lanes(8'hC0, c), gen_lanes(8'hB0, c), gen_exp(c, 4), c*8, 8,
                    1'b0, -1, -1, $sformatf("pre_abort%0d", c));
        capture(gen_lanes(8'hC0, 5), gen_lanes(8'hB0, 5), gen_exp(5, 4), 40, 8,
                1'b0, -1, 3, "abort5");
        count_quiet("post_abort", 6);
        capture(tbl[1].alpha, tbl[1].beta, tbl[1].exp, 0, 8, 1'b0, -1, -1, "restart");

        // L1 instance: reset in the middle of capture 2
        use_l1 = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        capture(gen_lanes(8'hC0, 0), gen_lanes(8'hB0, 0), gen_exp(0, 3), 0, 6,
                1'b0, -1, -1, "l1_c0");
        capture(gen_lanes(8'hC0, 1), gen_lanes(8'hB0, 1), gen_exp(1, 3), 6, 6,
                1'b0, -1, -1, "l1_c1");
        alpha = gen_lanes(8'hC0, 2);
        beta  = gen_lanes(8'hB0, 2);
        valid = 1'b1;
        step();
        valid = 1'b0;
        chk("l1_c2_w0_addr", c_addr, 32'd12);
        chk("l1_c2_w0_data", c_data, 32'hC0020000);
        step();
        chk("l1_c2_w1_addr", c_addr, 32'd13);
        chk("l1_c2_w1_data", c_data, 32'hC0020001);
        rst = 1'b1;
        step();
        chk_idle("l1_rst_a");
        chk("l1_rst_a_done", {31'd0, c_done}, 32'd0);
        step();
        chk_idle("l1_rst_b");
        chk("l1_rst_b_done", {31'd0, c_done}, 32'd0);
        rst = 1'b0;
        count_quiet("l1_post_rst", 5);
        start = 1'b1;
        step();
        start = 1'b0;
        capture(gen_lanes(8'hC0, 7), gen_lanes(8'hB0, 7), gen_exp(7, 3), 0, 6,
                1'b0, -1, -1, "l1_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
